// File: rtl/lsu_align.sv
// Load/store alignment unit: maps RV32I byte-addressed loads and stores onto a
// word-addressed data memory. Loads and SW finish in one cycle; SB/SH run a
// read-modify-write over two cycles and stall the core for one of them.
module lsu_align #(
    parameter int MEM_WORDS = 1024,
    parameter int IDX_BITS  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        stall,
    output logic        fault,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_rw,
    input  logic [31:0] mem_rdata
);

    typedef enum logic {IDLE, RMW_WR} state_t;

    localparam logic [29:0] MEM_LIMIT = 30'(MEM_WORDS);

    state_t              state;
    logic [31:0]         merge_q;
    logic [IDX_BITS-1:0] idx_q;

    logic [IDX_BITS-1:0] idx;
    logic                fault_c;
    logic                sub_store;
    logic [31:0]         merged;
    logic [31:0]         load_data;
    logic [7:0]          lane_byte;
    logic [15:0]         lane_half;

    assign idx = addr[IDX_BITS+1:2];

    // Misalignment, range and funct3 legality for the incoming request
    always_comb begin
        fault_c = 1'b0;
        if (addr[31:2] >= MEM_LIMIT)
            fault_c = 1'b1;
        if ((funct3 == 3'b001 || funct3 == 3'b101) && addr[0])
            fault_c = 1'b1;
        if (funct3 == 3'b010 && addr[1:0] != 2'b00)
            fault_c = 1'b1;
        if (req_we) begin
            if (funct3 != 3'b000 && funct3 != 3'b001 && funct3 != 3'b010)
                fault_c = 1'b1;
        end else begin
            if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111)
                fault_c = 1'b1;
        end
        sub_store = req_we && !fault_c && (funct3 == 3'b000 || funct3 == 3'b001);
    end

    // Lane extraction and extension for loads, lane replacement for SB/SH
    always_comb begin
        case (addr[1:0])
            2'd0:    lane_byte = mem_rdata[7:0];
            2'd1:    lane_byte = mem_rdata[15:8];
            2'd2:    lane_byte = mem_rdata[23:16];
            default: lane_byte = mem_rdata[31:24];
        endcase
        lane_half = addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        case (funct3)
            3'b000:  load_data = {{24{lane_byte[7]}}, lane_byte};
            3'b001:  load_data = {{16{lane_half[15]}}, lane_half};
            3'b100:  load_data = {24'h0, lane_byte};
            3'b101:  load_data = {16'h0, lane_half};
            default: load_data = mem_rdata;
        endcase

        merged = mem_rdata;
        if (funct3 == 3'b000) begin
            case (addr[1:0])
                2'd0:    merged[7:0]   = wdata[7:0];
                2'd1:    merged[15:8]  = wdata[7:0];
                2'd2:    merged[23:16] = wdata[7:0];
                default: merged[31:24] = wdata[7:0];
            endcase
        end else if (addr[1]) begin
            merged[31:16] = wdata[15:0];
        end else begin
            merged[15:0] = wdata[15:0];
        end
    end

    // RMW sequencing: capture merged word and index, then write it next cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            merge_q <= '0;
            idx_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && sub_store) begin
                        merge_q <= merged;
                        idx_q   <= idx;
                        state   <= RMW_WR;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output decode; gated by rst_n so a reset mid-write drops mem_rw at once
    always_comb begin
        rdata     = '0;
        done      = 1'b0;
        stall     = 1'b0;
        fault     = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_rw    = 1'b0;
        if (rst_n) begin
            case (state)
                IDLE: begin
                    mem_addr = {{(32-IDX_BITS){1'b0}}, idx};
                    if (req_valid) begin
                        if (fault_c) begin
                            fault = 1'b1;
                            done  = 1'b1;
                        end else if (!req_we) begin
                            rdata = load_data;
                            done  = 1'b1;
                        end else if (funct3 == 3'b010) begin
                            mem_rw    = 1'b1;
                            mem_wdata = wdata;
                            done      = 1'b1;
                        end else begin
                            stall = 1'b1;
                        end
                    end
                end
                default: begin
                    mem_rw    = 1'b1;
                    mem_addr  = {{(32-IDX_BITS){1'b0}}, idx_q};
                    mem_wdata = merge_q;
                    done      = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_align.sv
// Directed bench for lsu_align with a behavioural word memory attached.
module tb_lsu_align;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done;
    logic        stall;
    logic        fault;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rw;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:1023];
    logic        pre_we = 1'b0;
    logic [9:0]  pre_idx = '0;
    logic [31:0] pre_data = '0;

    int tests = 0;
    int fails = 0;

    lsu_align #(.MEM_WORDS(1024), .IDX_BITS(10)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
        .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata),
        .done(done), .stall(stall), .fault(fault), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rw(mem_rw), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[9:0]];

    // Word memory: whole-word write on posedge, plus a bench preload path
    always @(posedge clk) begin
        if (pre_we)
            mem[pre_idx] <= pre_data;
        else if (mem_rw)
            mem[mem_addr[9:0]] <= mem_wdata;
    end

    task automatic preload(input logic [9:0] i, input logic [31:0] d);
        @(negedge clk);
        req_valid = 1'b0;
        pre_we = 1'b1; pre_idx = i; pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic drive(input logic v, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        req_valid = v; req_we = we; funct3 = f3; addr = a; wdata = wd;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; funct3 = 3'b010;
        addr = 32'h14; wdata = 32'hFFFF_FFFF;
        #12;
        tests++;
        if ({rdata, done, stall, fault, mem_addr, mem_wdata, mem_rw} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: rdata=%h done=%b stall=%b fault=%b mem_addr=%h mem_wdata=%h mem_rw=%b, all must be 0",
                     rdata, done, stall, fault, mem_addr, mem_wdata, mem_rw);
        end
        @(negedge clk);
        req_valid = 1'b0; addr = 32'h0; wdata = 32'h0;
        rst_n = 1'b1;
        #1;
        tests++;
        if (mem_rw !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL idle_after_reset: mem_rw=%b done=%b, expected 0 0", mem_rw, done);
        end
    endtask

    task automatic test_loads();
        logic [2:0]  f3 [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        logic [31:0] ad [5] = '{32'h13, 32'h12, 32'h12, 32'h10, 32'h10};
        logic [31:0] ex [5] = '{32'hFFFF_FF88, 32'h0000_0099, 32'hFFFF_8899,
                                32'h0000_AABB, 32'h8899_AABB};
        preload(10'd4, 32'h8899_AABB);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, f3[i], ad[i], 32'h0);
            tests++;
            if (rdata !== ex[i] || done !== 1'b1 || stall !== 1'b0 || fault !== 1'b0) begin
                fails++;
                $display("FAIL load_%0d: rdata=%h done=%b stall=%b fault=%b, expected %h 1 0 0",
                         i, rdata, done, stall, fault, ex[i]);
            end
        end
    endtask

    task automatic test_sb();
        drive(1'b1, 1'b1, 3'b000, 32'h11, 32'h1234_56CC);
        tests++;
        if (stall !== 1'b1 || mem_rw !== 1'b0 || mem_addr !== 32'd4 || done !== 1'b0) begin
            fails++;
            $display("FAIL sb_cycle1: stall=%b mem_rw=%b mem_addr=%h done=%b, expected 1 0 4 0",
                     stall, mem_rw, mem_addr, done);
        end
        @(negedge clk); #1;
        tests++;
        if (mem_rw !== 1'b1 || mem_wdata !== 32'h8899_CCBB || done !== 1'b1 ||
            stall !== 1'b0 || rdata !== 32'h0) begin
            fails++;
            $display("FAIL sb_cycle2: mem_rw=%b mem_wdata=%h done=%b stall=%b rdata=%h, expected 1 8899ccbb 1 0 0",
                     mem_rw, mem_wdata, done, stall, rdata);
        end
        drive(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        tests++;
        if (rdata !== 32'h8899_CCBB || done !== 1'b1) begin
            fails++;
            $display("FAIL sb_readback: rdata=%h done=%b, expected 8899ccbb 1", rdata, done);
        end
    endtask

    task automatic test_back_to_back();
        preload(10'd4, 32'h8899_AABB);
        drive(1'b1, 1'b1, 3'b001, 32'h12, 32'h0000_BEEF);
        tests++;
        if (stall !== 1'b1) begin
            fails++;
            $display("FAIL sh_stall: stall=%b, expected 1", stall);
        end
        @(negedge clk); #1;
        tests++;
        if (mem_rw !== 1'b1 || mem_wdata !== 32'hBEEF_AABB || mem_addr !== 32'd4) begin
            fails++;
            $display("FAIL sh_write: mem_rw=%b mem_wdata=%h mem_addr=%h, expected 1 beefaabb 4",
                     mem_rw, mem_wdata, mem_addr);
        end
        drive(1'b1, 1'b1, 3'b010, 32'h14, 32'hDEAD_BEEF);
        tests++;
        if (done !== 1'b1 || stall !== 1'b0 || mem_rw !== 1'b1 || mem_addr !== 32'd5 ||
            mem_wdata !== 32'hDEAD_BEEF || rdata !== 32'h0) begin
            fails++;
            $display("FAIL sw_b2b: done=%b stall=%b mem_rw=%b mem_addr=%h mem_wdata=%h rdata=%h, expected 1 0 1 5 deadbeef 0",
                     done, stall, mem_rw, mem_addr, mem_wdata, rdata);
        end
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        tests++;
        if (mem[4] !== 32'hBEEF_AABB || mem[5] !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL b2b_mem: mem4=%h mem5=%h, expected beefaabb deadbeef", mem[4], mem[5]);
        end
    endtask

    task automatic test_faults();
        logic        we [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [2:0]  f3 [4] = '{3'b010, 3'b001, 3'b010, 3'b011};
        logic [31:0] ad [4] = '{32'h12, 32'h11, 32'h1000, 32'h10};
        preload(10'd0, 32'h0BAD_F00D);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, we[i], f3[i], ad[i], 32'hCAFE_F00D);
            tests++;
            if (fault !== 1'b1 || done !== 1'b1 || rdata !== 32'h0 ||
                mem_rw !== 1'b0 || stall !== 1'b0) begin
                fails++;
                $display("FAIL fault_%0d: fault=%b done=%b rdata=%h mem_rw=%b stall=%b, expected 1 1 0 0 0",
                         i, fault, done, rdata, mem_rw, stall);
            end
        end
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        tests++;
        if (mem[0] !== 32'h0BAD_F00D || mem[4] !== 32'hBEEF_AABB || mem[5] !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL fault_mem: mem0=%h mem4=%h mem5=%h, expected 0badf00d beefaabb deadbeef",
                     mem[0], mem[4], mem[5]);
        end
    endtask

    task automatic test_reset_in_rmw();
        drive(1'b1, 1'b1, 3'b000, 32'h10, 32'h0000_0077);
        @(negedge clk); #1;
        tests++;
        if (mem_rw !== 1'b1) begin
            fails++;
            $display("FAIL rmw_before_reset: mem_rw=%b, expected 1", mem_rw);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (mem_rw !== 1'b0) begin
            fails++;
            $display("FAIL async_drop: mem_rw=%b, expected 0 without clock edge", mem_rw);
        end
        req_valid = 1'b0; addr = 32'h0; wdata = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests++;
        if (mem[4] !== 32'hBEEF_AABB ||
            {rdata, done, stall, fault, mem_addr, mem_wdata, mem_rw} !== '0) begin
            fails++;
            $display("FAIL after_reset_rmw: mem4=%h done=%b stall=%b mem_rw=%b mem_addr=%h mem_wdata=%h, expected beefaabb and zeros",
                     mem[4], done, stall, mem_rw, mem_addr, mem_wdata);
        end
        drive(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        tests++;
        if (done !== 1'b1 || rdata !== 32'hBEEF_AABB) begin
            fails++;
            $display("FAIL idle_load_after_reset: done=%b rdata=%h, expected 1 beefaabb", done, rdata);
        end
    endtask

    task automatic test_rmw_ignores_inputs();
        preload(10'd8, 32'h1111_2222);
        drive(1'b1, 1'b1, 3'b000, 32'h13, 32'h0000_005A);
        @(negedge clk);
        req_valid = 1'b0; addr = 32'h20; wdata = 32'hFFFF_FFFF;
        #1;
        tests++;
        if (mem_rw !== 1'b1 || mem_addr !== 32'd4 || mem_wdata !== 32'h5AEF_AABB || done !== 1'b1) begin
            fails++;
            $display("FAIL rmw_ignore: mem_rw=%b mem_addr=%h mem_wdata=%h done=%b, expected 1 4 5aefaabb 1",
                     mem_rw, mem_addr, mem_wdata, done);
        end
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        tests++;
        if (mem[4] !== 32'h5AEF_AABB || mem[8] !== 32'h1111_2222) begin
            fails++;
            $display("FAIL rmw_ignore_mem: mem4=%h mem8=%h, expected 5aefaabb 11112222", mem[4], mem[8]);
        end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_sb();
        test_back_to_back();
        test_faults();
        test_reset_in_rmw();
        test_rmw_ignores_inputs();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lsu_align.md
Name: lsu_align

Overview:
- Load/store alignment unit between the single-cycle RV32I datapath (ALU address, rs2 data, funct3) and the word-addressed data memory.
- The data memory has a word-indexed address, a combinational read when its write enable is 0, and a whole-word write on posedge clk.
- This block handles the sub-word parts of RV32I on the core side:
  - converts byte addresses to word indices;
  - extracts and extends loaded bytes and halfwords;
  - performs SB/SH as a two-cycle read-modify-write, stalling the core for one cycle;
  - flags misaligned, out-of-range and illegal accesses.

Parameters:
- MEM_WORDS, 1024: number of 32-bit words in the data memory. Word indices at or above this value are out of range.
- IDX_BITS, 10: width of the used word index (log2 MEM_WORDS).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  core requests a memory access this cycle.
- req_we  input  1  1 = store, 0 = load.
- funct3  input  3  RV32I funct3:
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU;
  - stores: 000 SB, 001 SH, 010 SW.
- addr  input  32  byte address from the ALU.
- wdata  input  32  store data (rs2). Low byte or halfword used for SB/SH.
- rdata  output  32  aligned, extended load result.
- done  output  1  access completes this cycle.
- stall  output  1  core must hold PC and all request inputs next cycle.
- fault  output  1  misaligned, out-of-range or illegal-funct3 access.
- mem_addr  output  32  word index to memory, zero-extended {(32-IDX_BITS)'b0, addr[IDX_BITS+1:2]}.
- mem_wdata  output  32  word written to memory.
- mem_rw  output  1  memory write enable, 1 = write.
- mem_rdata  input  32  combinational read data from memory.

Behaviour:
- Clocking and reset:
  - One clock domain. rst_n is asynchronous, active-low.
  - While rst_n=0: state=IDLE, merge register=0, and all outputs are 0 (rdata, done, stall, fault, mem_addr, mem_wdata, mem_rw).
- States: IDLE and RMW_WR. In IDLE with req_valid=0, all outputs are 0 except mem_addr, which follows addr.
- Fault check (IDLE, req_valid=1), evaluated combinationally. fault=1 when any of:
  - LH/LHU/SH with addr[0]=1;
  - LW/SW with addr[1:0]!=0;
  - addr[31:2] >= MEM_WORDS;
  - load funct3 in {011, 110, 111};
  - store funct3 not in {000, 001, 010}.
- On a fault: done=1, rdata=0, mem_rw=0, stall=0, no state change. No memory write ever occurs on a faulting access.
- Loads (IDLE):
  - Zero latency: mem_rw=0, done=1, stall=0 in the same cycle.
  - Byte lane = addr[1:0]; half lane = addr[1].
  - LB/LH sign-extend. LBU/LHU zero-extend. LW passes mem_rdata unchanged.
- SW (IDLE): mem_rw=1, mem_wdata=wdata, done=1, stall=0. The memory commits the word on the same rising edge. The state stays IDLE.
- SB/SH, cycle 1 (IDLE):
  - Drive mem_rw=0 (read), stall=1, done=0.
  - On posedge, latch into the merge register: mem_rdata with the selected byte or half lane replaced by wdata[7:0] or wdata[15:0]. Also latch the word index. Go to RMW_WR.
- SB/SH, cycle 2 (RMW_WR):
  - Drive mem_rw=1, mem_addr=latched index, mem_wdata=merge register, done=1, stall=0.
  - Return to IDLE on posedge.
  - Request inputs are ignored in this state: a dropped req_valid or changed addr does not cancel or alter the write.
- rdata is 0 during any store.
- Back-to-back requests: a new request is accepted in the first IDLE cycle after RMW_WR. No bubble is added beyond the single RMW stall.
- Reset asserted in RMW_WR: mem_rw drops to 0 immediately (asynchronously). The write is abandoned and memory is unchanged.
- Only lanes selected by funct3/addr change. The other three bytes (SB) or halfword (SH) are preserved bit-exact.

Test Plan:
- Preload mem[4]=0x8899AABB. Loads in consecutive cycles, each giving done=1 the same cycle and stall=0:
  - LB 0x13 -> rdata=0xFFFFFF88;
  - LBU 0x12 -> 0x00000099;
  - LH 0x12 -> 0xFFFF8899;
  - LHU 0x10 -> 0x0000AABB;
  - LW 0x10 -> 0x8899AABB.
- SB addr 0x11, wdata=0x123456CC:
  - cycle 1: stall=1, mem_rw=0, mem_addr=4;
  - cycle 2: mem_rw=1, mem_wdata=0x8899CCBB, done=1;
  - a following LW 0x10 returns 0x8899CCBB.
- SH addr 0x12, wdata=0x0000BEEF, then SW 0x14 with wdata=0xDEADBEEF in the next IDLE cycle:
  - mem[4]=0xBEEFAABB and mem[5]=0xDEADBEEF;
  - the SW completes with zero stall.
- Faults, each -> fault=1, done=1, rdata=0, mem_rw never 1, memory unchanged:
  - LW 0x12;
  - SH 0x11;
  - SW 0x1000 (index 1024 >= MEM_WORDS);
  - load funct3=011.
- SB 0x10 with rst_n pulled low mid-cycle 2 (RMW_WR):
  - mem_rw falls without waiting for a clock edge;
  - mem[4] keeps its old value;
  - after release, state=IDLE and all outputs are 0.
- SB 0x13 with req_valid dropped and addr changed to 0x20 during RMW_WR: the write still goes to index 4 with only byte 3 replaced.
